// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkmon_pkg.sv
// Shared types and constants for the clock-activity monitor.
package gf180mcu_fd_sc_mcu9t5v0__clkmon_pkg;

  // Depth of the synchroniser chain: two metastability flops plus one history flop.
  localparam int SYNC_STAGES = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkmon_sync.sv
// Brings the monitored clock into the CLK domain and flags its rising edges.
// RISE is high for one CLK cycle, two cycles after I rises, so an edge is
// counted at the third CLK edge after it occurs.
module gf180mcu_fd_sc_mcu9t5v0__clkmon_sync
  import gf180mcu_fd_sc_mcu9t5v0__clkmon_pkg::*;
(
  input  logic CLK,
  input  logic RN,
  input  logic I,
  output logic RISE
);

  // sync_q[0..1] are the metastability flops, sync_q[2] holds the previous sample.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  // Shift the raw input into the chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], I};
  end

  // Synchroniser flops, cleared asynchronously.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign RISE = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkmon.sv
// Clock-activity monitor: counts rising edges of I over a window of WIN CLK
// cycles, reports the count with a one-cycle VLD pulse and raises a sticky
// FAIL when the count falls outside [LO, HI].
module gf180mcu_fd_sc_mcu9t5v0__clkmon
  import gf180mcu_fd_sc_mcu9t5v0__clkmon_pkg::*;
#(
  parameter int WIN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             I,
  input  logic             EN,
  input  logic [WIN_W-1:0] WIN,
  input  logic [CNT_W-1:0] LO,
  input  logic [CNT_W-1:0] HI,
  input  logic             CLR,
  output logic [CNT_W-1:0] CNT,
  output logic             VLD,
  output logic             FAIL,
  output logic             BUSY
);

  logic             rise;
  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             fail_q, fail_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] edge_inc;
  logic             out_of_range;
  logic             start_ok;

  gf180mcu_fd_sc_mcu9t5v0__clkmon_sync u_sync (
    .CLK  (CLK),
    .RN   (RN),
    .I    (I),
    .RISE (rise)
  );

  // Next-state logic for the window FSM, counters and report outputs.
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    cnt_d      = cnt_q;
    vld_d      = 1'b0;
    fail_d     = fail_q;

    // Saturating increment: once all ones, further edges are ignored.
    edge_inc = (rise && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    // LO > HI makes this true for every count, so such a window always fails.
    out_of_range = (cnt_q < LO) || (cnt_q > HI);
    // A zero-length window never starts.
    start_ok = EN && (WIN != '0);

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d    = ST_MEASURE;
          win_cnt_d  = WIN;
          edge_cnt_d = '0;
        end
      end
      ST_MEASURE: begin
        if (!EN) begin
          // Abort: no report, CNT and FAIL keep their previous values.
          state_d = ST_IDLE;
        end else begin
          edge_cnt_d = edge_inc;
          win_cnt_d  = win_cnt_q - WIN_W'(1);
          if (win_cnt_q == WIN_W'(1)) begin
            // Final cycle: its edge is included in the published count.
            state_d = ST_REPORT;
            cnt_d   = edge_inc;
            vld_d   = 1'b1;
          end
        end
      end
      ST_REPORT: begin
        // Edges seen here are dropped because the edge counter is reloaded.
        if (start_ok) begin
          state_d    = ST_MEASURE;
          win_cnt_d  = WIN;
          edge_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A failing report beats a simultaneous clear.
    if ((state_q == ST_REPORT) && out_of_range) fail_d = 1'b1;
    else if (CLR)                                fail_d = 1'b0;

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any window without a report.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= ST_IDLE;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
    end
  end

  assign CNT  = cnt_q;
  assign VLD  = vld_q;
  assign FAIL = fail_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkmon.sv
// Bench for the clock-activity monitor: directed windows on an 8-bit and a
// 4-bit instance, with a scoreboard checking every VLD report.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkmon;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn, i0, tog, en, clr, en4;
  logic [7:0] win, lo, hi, win4;
  logic [3:0] lo4, hi4;
  logic [7:0] cnt0;
  logic       vld0, fail0, busy0;
  logic [3:0] cnt4;
  logic       vld4, fail4, busy4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cnt;
    int fail;
  } exp_t;

  exp_t q0[$];
  exp_t q4[$];

  gf180mcu_fd_sc_mcu9t5v0__clkmon #(.WIN_W(8), .CNT_W(8)) dut (
    .CLK(clk), .RN(rn), .I(i0), .EN(en), .WIN(win), .LO(lo), .HI(hi), .CLR(clr),
    .CNT(cnt0), .VLD(vld0), .FAIL(fail0), .BUSY(busy0)
  );

  gf180mcu_fd_sc_mcu9t5v0__clkmon #(.WIN_W(8), .CNT_W(4)) dut4 (
    .CLK(clk), .RN(rn), .I(i0), .EN(en4), .WIN(win4), .LO(lo4), .HI(hi4), .CLR(1'b0),
    .CNT(cnt4), .VLD(vld4), .FAIL(fail4), .BUSY(busy4)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_vld(input bit sel, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((sel ? vld4 : vld0) !== 1'b1) && (n < maxc));
    if ((sel ? vld4 : vld0) !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL vld_timeout: no VLD on dut%0d within %0d cycles", sel ? 4 : 0, maxc);
    end
  endtask

  // Monitored clock: toggles once per CLK cycle just after the rising edge.
  initial begin
    i0 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tog) i0 = ~i0;
      else     i0 = 1'b0;
    end
  end

  // Scoreboard monitor: CNT checked with VLD, FAIL checked one cycle later.
  initial begin : mon
    exp_t e0, e4;
    bit   p0, p4;
    p0 = 1'b0;
    p4 = 1'b0;
    forever begin
      @(negedge clk);
      if (p0) begin chk("fail0_after_vld", fail0, e0.fail); p0 = 1'b0; end
      if (p4) begin chk("fail4_after_vld", fail4, e4.fail); p4 = 1'b0; end
      if (vld0 === 1'b1) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL vld0_unexpected: got VLD=1 CNT=%0d expected no report", cnt0);
        end else begin
          e0 = q0.pop_front();
          chk("cnt0", cnt0, e0.cnt);
          p0 = 1'b1;
        end
      end
      if (vld4 === 1'b1) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL vld4_unexpected: got VLD=1 CNT=%0d expected no report", cnt4);
        end else begin
          e4 = q4.pop_front();
          chk("cnt4", cnt4, e4.cnt);
          p4 = 1'b1;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int n;
    rn = 1'b0; tog = 1'b0; en = 1'b0; clr = 1'b0; en4 = 1'b0;
    win = '0; lo = '0; hi = '0; win4 = '0; lo4 = '0; hi4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_cnt", cnt0, 0);
    chk("rst_vld", vld0, 0);
    chk("rst_fail", fail0, 0);
    chk("rst_busy", busy0, 0);
    rn = 1'b1;
    tog = 1'b1;

    // WIN=0 with EN high: stays idle.
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_win0", busy0, 0);

    // Toggling I, WIN=10, bounds 4..6: five edges, pass.
    lo = 8'd4; hi = 8'd6; win = 8'd10;
    q0.push_back('{5, 0});
    wait_vld(1'b0, 30, n);
    chk("lat_win10", n, 11);
    en = 1'b0;
    @(negedge clk);
    chk("busy_after_report", busy0, 0);

    // EN dropped at cycle 5: abort, no report, CNT holds 5.
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_mid", busy0, 1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy0, 0);
    chk("abort_cnt", cnt0, 5);
    chk("abort_fail", fail0, 0);
    repeat (12) @(negedge clk);

    // I stuck low, LO=1: count 0 fails and stays failed until CLR.
    tog = 1'b0;
    repeat (4) @(negedge clk);
    lo = 8'd1; en = 1'b1;
    q0.push_back('{0, 1});
    wait_vld(1'b0, 30, n);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("fail_sticky", fail0, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("fail_cleared", fail0, 0);

    // CLR held through a failing REPORT: set wins.
    clr = 1'b1; en = 1'b1;
    q0.push_back('{0, 1});
    wait_vld(1'b0, 30, n);
    en = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("fail_kept", fail0, 1);

    // 4-bit counter, WIN=100: 50 edges saturate at 15, HI=14 fails.
    tog = 1'b1;
    repeat (4) @(negedge clk);
    lo4 = 4'd0; hi4 = 4'd14; win4 = 8'd100; en4 = 1'b1;
    q4.push_back('{15, 1});
    wait_vld(1'b1, 150, n);
    en4 = 1'b0;
    @(negedge clk);

    // Reset mid-window: outputs clear at once, window restarts after release.
    lo = 8'd4; hi = 8'd6; win = 8'd10; en = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy0, 1);
    rn = 1'b0;
    #1;
    chk("arst_cnt", cnt0, 0);
    chk("arst_vld", vld0, 0);
    chk("arst_fail", fail0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_fail4", fail4, 0);
    chk("arst_cnt4", cnt4, 0);
    repeat (2) @(negedge clk);
    begin
      int k;
      k = 0;
      while ((i0 !== 1'b1) && (k < 4)) begin
        @(negedge clk);
        k++;
      end
    end
    rn = 1'b1;
    q0.push_back('{5, 0});
    wait_vld(1'b0, 30, n);
    chk("lat_after_reset", n, 11);
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__clkmon.md
GF180MCU_FD_SC_MCU9T5V0__CLKMON -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__clkmon

Interface
REQ-001 SHALL have parameter WIN_W, default 8, width of the window-length input and window counter.
REQ-002 SHALL have parameter CNT_W, default 8, width of the edge count and the bound inputs.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port I  input  1  monitored clock, e.g. a clkbuf output; asynchronous to CLK.
REQ-006 SHALL have port EN  input  1  run enable for back-to-back measurement windows.
REQ-007 SHALL have port WIN  input  WIN_W  window length in CLK cycles.
REQ-008 SHALL have ports LO and HI  input  CNT_W each  inclusive pass bounds on the edge count.
REQ-009 SHALL have port CLR  input  1  synchronous clear of FAIL.
REQ-010 SHALL have port CNT  output  CNT_W  edge count of the last completed window.
REQ-011 SHALL have port VLD  output  1  one-cycle pulse when CNT updates.
REQ-012 SHALL have port FAIL  output  1  sticky out-of-range flag.
REQ-013 SHALL have port BUSY  output  1  high while in MEASURE or REPORT.

Function
REQ-014 SHALL synchronise I through two flops, then take a third flop; a rising edge is sync2 AND NOT sync3.
REQ-015 SHALL count an I rising edge 3 CLK cycles after it occurs; at most one edge is counted per 2 CLK cycles.
REQ-016 SHALL implement three states: IDLE, MEASURE and REPORT.
REQ-017 SHALL, in IDLE with EN=1 and WIN!=0: go to MEASURE, load the window counter with WIN and clear the edge counter.
REQ-018 SHALL stay in IDLE when EN=1 and WIN=0; no window starts and VLD stays low.
REQ-019 SHALL, in MEASURE, decrement the window counter once per cycle and increment the edge counter on each detected edge.
REQ-020 SHALL saturate the edge counter at 2^CNT_W-1; it SHALL NOT wrap.
REQ-021 SHALL end a window after exactly WIN MEASURE cycles, count an edge detected in the final cycle, and go to REPORT.
REQ-022 SHALL, in REPORT (one cycle): drive VLD=1 with CNT holding the final count; set FAIL if CNT<LO or CNT>HI, with LO and HI sampled in that cycle.
REQ-023 SHALL, after REPORT, return to MEASURE with WIN reloaded if EN=1, otherwise go to IDLE.
REQ-024 SHALL discard edges detected during the REPORT cycle.
REQ-025 SHALL, on EN=0 during MEASURE, go to IDLE next cycle: no VLD, CNT and FAIL unchanged.
REQ-026 SHALL, when LO>HI, fail every window.
REQ-027 SHALL clear FAIL on CLR=1; if CLR and a fail condition occur in the same cycle, the set wins.
REQ-028 SHALL sample WIN only at window start; changes mid-window have no effect on the current window.

Reset
REQ-029 SHALL, on RN=0, immediately force: state IDLE, all sync flops 0, counters 0, CNT=0, VLD=0, FAIL=0, BUSY=0.
REQ-030 SHALL abort an active window on reset without emitting VLD, and resume per REQ-017 after RN rises.

Structure
REQ-031 SHALL place the state enum and the sync stage count (3) in package gf180mcu_fd_sc_mcu9t5v0__clkmon_pkg.
REQ-032 SHALL place the synchroniser and edge detector in sub-module gf180mcu_fd_sc_mcu9t5v0__clkmon_sync (ports CLK, RN, I, RISE).
REQ-033 SHALL be fully synchronous to CLK apart from RN, and SHALL contain no latches or combinational loops.

Verification
REQ-034 SHALL cover: WIN=10, I toggling every CLK cycle, LO=4, HI=6 -> VLD pulse with CNT=5, FAIL=0.
REQ-035 SHALL cover: I stuck at 0, WIN=10, LO=1 -> CNT=0, FAIL=1 that stays set until CLR, then clears.
REQ-036 SHALL cover: CNT_W=4, WIN=100, I toggling every cycle -> CNT=15 (saturated), FAIL set when HI=14.
REQ-037 SHALL cover: EN dropped at cycle 5 of a 10-cycle window -> no VLD, CNT keeps its prior value, IDLE next cycle.
REQ-038 SHALL cover: RN pulsed low mid-window -> all outputs 0 at once; with EN held high a full window restarts and VLD follows WIN+1 cycles after RN rises.
REQ-039 SHALL cover: CLR asserted in a REPORT cycle with a failing count -> FAIL=1.
